voxel_stepper: RTL

- 3D DDA traversal engine directly downstream of the ray job register.
- Consumes the latched job fields and `job_loaded` pulse, then walks the voxel grid one voxel per step.
- Queries an external occupancy store for each voxel and reports the first hit, grid exit, or step-limit exhaustion.
- Drives `job_done` back upstream when its result is accepted, freeing the job slot.

---
 rtl/voxel_stepper.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/voxel_stepper.sv
// voxel_stepper: 3D DDA voxel traversal engine.
// Walks the voxel grid one voxel per step, querying an external occupancy store
// for each voxel. It stops on the first solid voxel, on grid exit, or when the
// step limit is reached, and then holds the result until the consumer accepts it.
// Optional feature macro: VOXEL_STEPPER_PERF_EN adds the perf_cycles output.
module voxel_stepper #(
    parameter int unsigned X_BITS         = 5,
    parameter int unsigned Y_BITS         = 5,
    parameter int unsigned Z_BITS         = 5,
    parameter int unsigned W              = 24,
    parameter int unsigned MAX_STEPS_BITS = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      job_loaded,
    input  logic [X_BITS-1:0]         ix0,
    input  logic [Y_BITS-1:0]         iy0,
    input  logic [Z_BITS-1:0]         iz0,
    input  logic                      sx,
    input  logic                      sy,
    input  logic                      sz,
    input  logic [W-1:0]              next_x,
    input  logic [W-1:0]              next_y,
    input  logic [W-1:0]              next_z,
    input  logic [W-1:0]              inc_x,
    input  logic [W-1:0]              inc_y,
    input  logic [W-1:0]              inc_z,
    input  logic [MAX_STEPS_BITS-1:0] max_steps,
    output logic                      q_valid,
    output logic [X_BITS-1:0]         q_x,
    output logic [Y_BITS-1:0]         q_y,
    output logic [Z_BITS-1:0]         q_z,
    input  logic                      occ_valid,
    input  logic                      occ_hit,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic                      res_hit,
    output logic [1:0]                res_reason,
    output logic [X_BITS-1:0]         res_x,
    output logic [Y_BITS-1:0]         res_y,
    output logic [Z_BITS-1:0]         res_z,
    output logic [1:0]                res_face,
    output logic [MAX_STEPS_BITS-1:0] res_steps,
`ifdef VOXEL_STEPPER_PERF_EN
    output logic [15:0]               perf_cycles,
`endif
    output logic                      job_done
);

    typedef enum logic [1:0] {StIdle, StQuery, StWait, StDone} state_e;

    localparam logic [1:0] ReasonHit  = 2'd0;
    localparam logic [1:0] ReasonExit = 2'd1;
    localparam logic [1:0] ReasonMax  = 2'd2;
    localparam logic [1:0] FaceNone   = 2'd3;

    localparam logic [X_BITS-1:0]         OneX = 1;
    localparam logic [Y_BITS-1:0]         OneY = 1;
    localparam logic [Z_BITS-1:0]         OneZ = 1;
    localparam logic [MAX_STEPS_BITS-1:0] OneS = 1;

    state_e                    state_q, state_d;
    logic [X_BITS-1:0]         px_q, px_d;
    logic [Y_BITS-1:0]         py_q, py_d;
    logic [Z_BITS-1:0]         pz_q, pz_d;
    logic [W-1:0]              nx_q, nx_d, ny_q, ny_d, nz_q, nz_d;
    logic [W-1:0]              incx_q, incx_d, incy_q, incy_d, incz_q, incz_d;
    logic                      sx_q, sx_d, sy_q, sy_d, sz_q, sz_d;
    logic [MAX_STEPS_BITS-1:0] max_q, max_d, steps_q, steps_d;
    logic [1:0]                face_q, face_d, reason_q, reason_d;

    logic [1:0] axis;
    logic       x_edge, y_edge, z_edge, axis_edge;

    // Unsigned add that clamps at all-ones instead of wrapping.
    function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[W] ? {W{1'b1}} : s[W-1:0];
    endfunction

    // Smallest boundary distance picks the step axis; ties favour x, then y.
    always_comb begin
        if (nx_q <= ny_q && nx_q <= nz_q) begin
            axis = 2'd0;
        end else if (ny_q <= nz_q) begin
            axis = 2'd1;
        end else begin
            axis = 2'd2;
        end
    end

    // A voxel on the grid boundary facing the step direction cannot advance.
    assign x_edge    = sx_q ? (&px_q) : ~(|px_q);
    assign y_edge    = sy_q ? (&py_q) : ~(|py_q);
    assign z_edge    = sz_q ? (&pz_q) : ~(|pz_q);
    assign axis_edge = (axis == 2'd0) ? x_edge : (axis == 2'd1) ? y_edge : z_edge;

    // Next-state logic for the traversal FSM and its datapath.
    always_comb begin
        state_d  = state_q;
        px_d     = px_q;
        py_d     = py_q;
        pz_d     = pz_q;
        nx_d     = nx_q;
        ny_d     = ny_q;
        nz_d     = nz_q;
        incx_d   = incx_q;
        incy_d   = incy_q;
        incz_d   = incz_q;
        sx_d     = sx_q;
        sy_d     = sy_q;
        sz_d     = sz_q;
        max_d    = max_q;
        steps_d  = steps_q;
        face_d   = face_q;
        reason_d = reason_q;
        unique case (state_q)
            StIdle: begin
                if (job_loaded) begin
                    state_d = StQuery;
                    px_d    = ix0;
                    py_d    = iy0;
                    pz_d    = iz0;
                    nx_d    = next_x;
                    ny_d    = next_y;
                    nz_d    = next_z;
                    incx_d  = inc_x;
                    incy_d  = inc_y;
                    incz_d  = inc_z;
                    sx_d    = sx;
                    sy_d    = sy;
                    sz_d    = sz;
                    max_d   = max_steps;
                    steps_d = '0;
                    face_d  = FaceNone;
                end
            end
            StQuery: begin
                state_d = StWait;
            end
            StWait: begin
                if (occ_valid) begin
                    if (occ_hit) begin
                        state_d  = StDone;
                        reason_d = ReasonHit;
                    end else if (steps_q == max_q) begin
                        state_d  = StDone;
                        reason_d = ReasonMax;
                    end else if (axis_edge) begin
                        state_d  = StDone;
                        reason_d = ReasonExit;
                        face_d   = axis;
                    end else begin
                        state_d = StQuery;
                        steps_d = steps_q + OneS;
                        face_d  = axis;
                        case (axis)
                            2'd0: begin
                                px_d = sx_q ? px_q + OneX : px_q - OneX;
                                nx_d = sat_add(nx_q, incx_q);
                            end
                            2'd1: begin
                                py_d = sy_q ? py_q + OneY : py_q - OneY;
                                ny_d = sat_add(ny_q, incy_q);
                            end
                            default: begin
                                pz_d = sz_q ? pz_q + OneZ : pz_q - OneZ;
                                nz_d = sat_add(nz_q, incz_q);
                            end
                        endcase
                    end
                end
            end
            StDone: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

`ifdef VOXEL_STEPPER_PERF_EN
    logic [15:0] perf_q, perf_d;

    // Busy-cycle counter: restarts on an accepted job, saturates, holds while idle.
    always_comb begin
        perf_d = perf_q;
        if (state_q == StIdle) begin
            if (job_loaded) begin
                perf_d = '0;
            end
        end else if (perf_q != 16'hFFFF) begin
            perf_d = perf_q + 16'd1;
        end
    end

    // Performance counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`endif

    // State and datapath registers; reset abandons any job in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            px_q     <= '0;
            py_q     <= '0;
            pz_q     <= '0;
            nx_q     <= '0;
            ny_q     <= '0;
            nz_q     <= '0;
            incx_q   <= '0;
            incy_q   <= '0;
            incz_q   <= '0;
            sx_q     <= 1'b0;
            sy_q     <= 1'b0;
            sz_q     <= 1'b0;
            max_q    <= '0;
            steps_q  <= '0;
            face_q   <= FaceNone;
            reason_q <= ReasonHit;
        end else begin
            state_q  <= state_d;
            px_q     <= px_d;
            py_q     <= py_d;
            pz_q     <= pz_d;
            nx_q     <= nx_d;
            ny_q     <= ny_d;
            nz_q     <= nz_d;
            incx_q   <= incx_d;
            incy_q   <= incy_d;
            incz_q   <= incz_d;
            sx_q     <= sx_d;
            sy_q     <= sy_d;
            sz_q     <= sz_d;
            max_q    <= max_d;
            steps_q  <= steps_d;
            face_q   <= face_d;
            reason_q <= reason_d;
        end
    end

    assign q_valid    = (state_q == StQuery);
    assign q_x        = px_q;
    assign q_y        = py_q;
    assign q_z        = pz_q;
    assign res_valid  = (state_q == StDone);
    // Reset value of reason_q encodes HIT, so qualify with res_valid.
    assign res_hit    = res_valid && (reason_q == ReasonHit);
    assign res_reason = reason_q;
    assign res_x      = px_q;
    assign res_y      = py_q;
    assign res_z      = pz_q;
    assign res_face   = face_q;
    assign res_steps  = steps_q;
    assign job_done   = res_valid && res_ready;

endmodule
